// File: rtl/game_pkg.sv
// Shared types and constants for the game controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int SCORE_W     = 16;
  localparam int FPP_DEFAULT = 6;
  localparam int FCNT_W      = 6;

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// Four-digit BCD counter with synchronous clear and enable; 9999 wraps to 0000.
// Latency: count updates on the rising edge after en_i/clr_i; clear has priority.
// Backpressure: none, en_i is a single-cycle increment request.
module bcd_counter4
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [SCORE_W-1:0] cnt_o
);

  logic [SCORE_W-1:0] cnt_q, cnt_d;
  logic               carry;

  // Ripple the increment through the digits, LSD first; a 9 wraps and carries.
  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b1;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (cnt_q[4*i +: 4] == 4'd9) begin
            cnt_d[4*i +: 4] = 4'd0;
          end else begin
            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/game_ctrl.sv
// Game state machine, collision latch, frame-based scoring and pixel merge (hiscore via GAME_CTRL_HISCORE_EN).
// Latency: state 1 cycle after a button edge / frame end; status, game_over and px_out 1 further cycle.
// Backpressure: none; buttons are edge-detected levels, fresh is a free-running frame strobe.
module game_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_POINT = FPP_DEFAULT
)
(
  input  logic               clk,
  input  logic               RESET,
  input  logic               START,
  input  logic               PAUSE,
  input  logic               fresh,
  input  logic               px_dino,
  input  logic               px_cactus,
  output logic               game_status,
  output logic               game_over,
  output logic               px_out,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore
);

  localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(FRAMES_PER_POINT - 1);

  state_t            state_q, state_d;
  logic              start_q, pause_q, arm_q;
  logic              fresh_q, frame_end_q;
  logic              hit_q, hit_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              status_q, over_q, px_q, px_d;
  logic              start_edge, pause_edge;
  logic              clr_game, score_tick, point;

  // arm_q is low only in the first cycle after reset, so a button held
  // through reset release never registers as an edge.
  assign start_edge = START & ~start_q & arm_q;
  assign pause_edge = PAUSE & ~pause_q & arm_q;

  // A frame that ends in a collision earns no point and does not advance the counter.
  assign score_tick = (state_q == ST_RUN) && frame_end_q && !hit_q;
  assign point      = score_tick && (fcnt_q == LAST_FRAME);

  // Next state; collision at frame end outranks any simultaneous button edge.
  always_comb begin
    state_d  = state_q;
    clr_game = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d  = ST_RUN;
          clr_game = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end_q && hit_q) state_d = ST_OVER;
        else if (pause_edge)      state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (start_edge) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame counter, collision latch and merged pixel next values.
  always_comb begin
    fcnt_d = fcnt_q;
    if (clr_game)        fcnt_d = '0;
    else if (point)      fcnt_d = '0;
    else if (score_tick) fcnt_d = fcnt_q + 1'b1;

    hit_d = hit_q | (fresh & px_dino & px_cactus);
    if (state_q != ST_RUN || frame_end_q) hit_d = 1'b0;

    px_d = px_dino | px_cactus;
    if (fresh && over_q && px_dino) px_d = 1'b1;
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      arm_q       <= 1'b0;
      fresh_q     <= 1'b0;
      frame_end_q <= 1'b0;
      hit_q       <= 1'b0;
      fcnt_q      <= '0;
      status_q    <= 1'b0;
      over_q      <= 1'b0;
      px_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= START;
      pause_q     <= PAUSE;
      arm_q       <= 1'b1;
      fresh_q     <= fresh;
      frame_end_q <= fresh_q & ~fresh;
      hit_q       <= hit_d;
      fcnt_q      <= fcnt_d;
      status_q    <= (state_q == ST_RUN);
      over_q      <= (state_q == ST_OVER);
      px_q        <= px_d;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst   (RESET),
    .clr_i (clr_game),
    .en_i  (point),
    .cnt_o (score)
  );

`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  // Valid BCD orders the same as binary, so a plain compare suffices.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      hiscore_q <= '0;
    end else if (state_q == ST_RUN && state_d == ST_OVER && score > hiscore_q) begin
      hiscore_q <= score;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign game_status = status_q;
  assign game_over   = over_q;
  assign px_out      = px_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: main instance at 6 frames/point, second at 1 frame/point for BCD wrap.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, pause, fresh, dino, cactus;
  logic        status, over, px;
  logic [15:0] score, hiscore;
  logic        start2, fresh2, zero;
  logic        status2, over2, px2;
  logic [15:0] score2, hiscore2;
  logic [15:0] hi_exp;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  game_ctrl #(.FRAMES_PER_POINT(6)) dut (
    .clk(clk), .RESET(rst), .START(start), .PAUSE(pause), .fresh(fresh),
    .px_dino(dino), .px_cactus(cactus), .game_status(status), .game_over(over),
    .px_out(px), .score(score), .hiscore(hiscore)
  );

  game_ctrl #(.FRAMES_PER_POINT(1)) dut2 (
    .clk(clk), .RESET(rst), .START(start2), .PAUSE(zero), .fresh(fresh2),
    .px_dino(zero), .px_cactus(zero), .game_status(status2), .game_over(over2),
    .px_out(px2), .score(score2), .hiscore(hiscore2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: 4 active cycles (optional 1-cycle overlap), 4 blanking cycles.
  // sel raises PAUSE (1) or START (2) exactly in the frame-end pulse cycle.
  task automatic frame(input bit hit, input int sel);
    fresh = 1'b1;
    cyc(2);
    if (hit) begin dino = 1'b1; cactus = 1'b1; end
    cyc(1);
    dino = 1'b0; cactus = 1'b0;
    cyc(1);
    fresh = 1'b0;
    cyc(1);
    if (sel == 1) pause = 1'b1;
    if (sel == 2) start = 1'b1;
    cyc(1);
    pause = 1'b0; start = 1'b0;
    cyc(2);
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b0, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(2); start = 1'b0; cyc(1);
  endtask

  task automatic frame2();
    fresh2 = 1'b1; cyc(1); fresh2 = 1'b0; cyc(1);
  endtask

  initial begin
`ifdef GAME_CTRL_HISCORE_EN
    hi_exp = 16'h0012;
`else
    hi_exp = 16'h0000;
`endif
    rst = 1'b1; start = 1'b1; pause = 1'b0; fresh = 1'b0; dino = 1'b0; cactus = 1'b0;
    start2 = 1'b0; fresh2 = 1'b0; zero = 1'b0;
    cyc(3);
    check("rst_status", {15'd0, status}, 16'h0000);
    check("rst_over",   {15'd0, over},   16'h0000);
    check("rst_px",     {15'd0, px},     16'h0000);
    check("rst_score",  score,   16'h0000);
    check("rst_hiscore", hiscore, 16'h0000);

    // START held through reset release must not start the game
    rst = 1'b0;
    cyc(5);
    check("held_start_idle", {15'd0, status}, 16'h0000);

    // px_out registered, 1-cycle latency
    start = 1'b0; cactus = 1'b1;
    #1 check("px_not_comb", {15'd0, px}, 16'h0000);
    cyc(1);
    check("px_reg", {15'd0, px}, 16'h0001);
    cactus = 1'b0;
    cyc(1);
    check("px_clear", {15'd0, px}, 16'h0000);

    // START edge: status rises two cycles later
    start = 1'b1;
    cyc(1);
    check("status_lat1", {15'd0, status}, 16'h0000);
    cyc(1);
    check("status_lat2", {15'd0, status}, 16'h0001);
    check("start_score", score, 16'h0000);
    cyc(3);
    start = 1'b0;

    // 60 frames at 6 frames/point, with a digit carry
    frames(59);
    check("score_59f", score, 16'h0009);
    frames(1);
    check("score_60f", score, 16'h0010);

    // pause mid-count: counter and score held
    frames(3);
    pause = 1'b1; cyc(2); pause = 1'b0; cyc(2);
    check("paused_status", {15'd0, status}, 16'h0000);
    frames(10);
    check("paused_score", score, 16'h0010);
    pulse_start();
    cyc(1);
    check("resume_status", {15'd0, status}, 16'h0001);
    frames(2);
    check("resume_hold", score, 16'h0010);
    frames(1);
    check("resume_point", score, 16'h0011);
    frames(6);
    check("score_0012", score, 16'h0012);

    // collision on the frame that would have scored
    frames(5);
    check("pre_hit", score, 16'h0012);
    frame(1'b1, 0);
    check("hit_over",   {15'd0, over},   16'h0001);
    check("hit_status", {15'd0, status}, 16'h0000);
    check("hit_frozen", score, 16'h0012);
    check("hiscore_g1", hiscore, hi_exp);
    frames(2);
    check("over_frozen", score, 16'h0012);
    fresh = 1'b1; dino = 1'b1;
    cyc(1);
    check("px_solid", {15'd0, px}, 16'h0001);
    fresh = 1'b0; dino = 1'b0;
    cyc(2);

    // second game: restart clears score; PAUSE edge loses to collision
    pulse_start();
    cyc(1);
    check("g2_score", score, 16'h0000);
    check("g2_over",  {15'd0, over}, 16'h0000);
    frames(42);
    check("g2_0007", score, 16'h0007);
    frame(1'b1, 1);
    check("pause_vs_hit", {15'd0, over}, 16'h0001);
    check("g2_frozen", score, 16'h0007);
    check("hiscore_g2", hiscore, hi_exp);

    // third game: START edge loses to collision
    pulse_start();
    frame(1'b1, 2);
    check("start_vs_hit", {15'd0, over}, 16'h0001);
    check("g3_score", score, 16'h0000);

    // 1 frame/point instance: boundary and 9999 wrap
    start2 = 1'b1; cyc(2); start2 = 1'b0; cyc(1);
    frame2(); cyc(2);
    check("fpp1_first", score2, 16'h0001);
    repeat (9998) frame2();
    cyc(2);
    check("score_9999", score2, 16'h9999);
    frame2(); cyc(2);
    check("wrap_0000", score2, 16'h0000);
    check("fpp1_status", {15'd0, status2}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
